// File: rtl/frame_composer.sv
// Frame composer: runs sprite engines in priority order and turns their pixel streams into frame-buffer writes.
// Optional background clear phase is compiled in with `define COMPOSER_CLEAR_EN.
module frame_composer #(
   parameter int          N_ENG    = 4,
   parameter int          SCR_W    = 320,
   parameter int          SCR_H    = 240,
   parameter logic [5:0]  BG_INDEX = 6'd0
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 frame_start,
   output logic [N_ENG-1:0]     eng_start,
   input  logic [N_ENG-1:0]     eng_done,
   input  logic [9*N_ENG-1:0]   eng_x,
   input  logic [8*N_ENG-1:0]   eng_y,
   input  logic [7*N_ENG-1:0]   eng_color,
   output logic                 fb_we,
   output logic [16:0]          fb_addr,
   output logic [5:0]           fb_data,
   output logic                 buf_sel,
   output logic                 busy,
   output logic                 frame_done,
   output logic                 overrun,
   output logic [2:0]           state_dbg
);

   localparam int          IW    = (N_ENG > 1) ? $clog2(N_ENG) : 1;
   localparam logic [8:0]  X_LIM = 9'(SCR_W);
   localparam logic [8:0]  Y_LIM = 9'(SCR_H);

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      START  = 3'd1,
      SKIP   = 3'd2,
      DRAW   = 3'd3,
      FINISH = 3'd4
`ifdef COMPOSER_CLEAR_EN
      , CLEAR = 3'd5
`endif
   } state_t;

   state_t        state, next_state;
   logic [IW-1:0] idx, next_idx;
   logic [8:0]    sel_x;
   logic [7:0]    sel_y;
   logic [6:0]    sel_color;
   logic          sel_done, last_eng, pix_ok;
   logic [16:0]   pix_addr;
   logic          wr_en;
   logic [16:0]   wr_addr;
   logic [5:0]    wr_data;

`ifdef COMPOSER_CLEAR_EN
   localparam logic [16:0] CLR_LAST = 17'(SCR_W * SCR_H - 1);
   logic [16:0] clr_cnt;
`endif

   // Only the selected engine's stream is looked at; everything else is ignored.
   always_comb begin
      sel_x     = eng_x[int'(idx)*9 +: 9];
      sel_y     = eng_y[int'(idx)*8 +: 8];
      sel_color = eng_color[int'(idx)*7 +: 7];
      sel_done  = eng_done[idx];
      last_eng  = (idx == IW'(N_ENG - 1));
      pix_ok    = sel_color[6] && (sel_x < X_LIM) && ({1'b0, sel_y} < Y_LIM);
      pix_addr  = ({9'd0, sel_y} << 8) + ({9'd0, sel_y} << 6) + {8'd0, sel_x};
   end

   always_comb begin
      next_state = state;
      next_idx   = idx;
      wr_en      = 1'b0;
      wr_addr    = pix_addr;
      wr_data    = sel_color[5:0];
      case (state)
         IDLE: begin
            if (frame_start) begin
               next_idx = '0;
`ifdef COMPOSER_CLEAR_EN
               next_state = CLEAR;
`else
               next_state = START;
`endif
            end
         end
`ifdef COMPOSER_CLEAR_EN
         CLEAR: begin
            wr_en   = 1'b1;
            wr_addr = clr_cnt;
            wr_data = BG_INDEX;
            if (clr_cnt == CLR_LAST) next_state = START;
         end
`endif
         START:  next_state = SKIP;
         SKIP:   next_state = DRAW;
         DRAW: begin
            if (sel_done) begin
               if (last_eng) begin
                  next_state = FINISH;
               end else begin
                  next_idx   = idx + 1'b1;
                  next_state = START;
               end
            end else begin
               wr_en = pix_ok;
            end
         end
         FINISH: begin
            next_state = IDLE;
            next_idx   = '0;
         end
         default: begin
            next_state = IDLE;
            next_idx   = '0;
         end
      endcase
   end

   always_comb begin
      eng_start = '0;
      if (state == START) eng_start[idx] = 1'b1;
   end

   assign busy       = (state != IDLE);
   assign frame_done = (state == FINISH);
   assign overrun    = frame_start && busy;
   assign state_dbg  = state;

   // buf_sel flips on entry to FINISH so it changes together with frame_done.
   always_ff @(posedge clk) begin
      if (reset) begin
         state   <= IDLE;
         idx     <= '0;
         buf_sel <= 1'b0;
         fb_we   <= 1'b0;
         fb_addr <= '0;
         fb_data <= '0;
      end else begin
         state   <= next_state;
         idx     <= next_idx;
         fb_we   <= wr_en;
         fb_addr <= wr_en ? wr_addr : '0;
         fb_data <= wr_en ? wr_data : '0;
         if (state == DRAW && sel_done && last_eng) buf_sel <= ~buf_sel;
      end
   end

`ifdef COMPOSER_CLEAR_EN
   always_ff @(posedge clk) begin
      if (reset || state != CLEAR) clr_cnt <= '0;
      else                         clr_cnt <= clr_cnt + 17'd1;
   end
`endif

endmodule

// File: tb/tb_frame_composer.sv
// Bench for frame_composer: directed sprite tables, expected writes queued up front, monitor checks fb writes.
// Build with COMPOSER_CLEAR_EN defined to exercise the clear phase instead of the sprite tests.
module tb_frame_composer;

   logic          clk = 1'b0;
   logic          reset;
   logic          frame_start;
   logic [3:0]    eng_start;
   logic [3:0]    eng_done;
   logic [35:0]   eng_x;
   logic [31:0]   eng_y;
   logic [27:0]   eng_color;
   logic          fb_we;
   logic [16:0]   fb_addr;
   logic [5:0]    fb_data;
   logic          buf_sel, busy, frame_done, overrun;
   logic [2:0]    state_dbg;

   int            n_checks = 0;
   int            n_fail   = 0;
   logic [22:0]   exp_q[$];

   int            px_n[4];
   logic [8:0]    px_x[4][8];
   logic [7:0]    px_y[4][8];
   logic [6:0]    px_c[4][8];

   frame_composer dut (
      .clk(clk), .reset(reset), .frame_start(frame_start),
      .eng_start(eng_start), .eng_done(eng_done),
      .eng_x(eng_x), .eng_y(eng_y), .eng_color(eng_color),
      .fb_we(fb_we), .fb_addr(fb_addr), .fb_data(fb_data),
      .buf_sel(buf_sel), .busy(busy), .frame_done(frame_done),
      .overrun(overrun), .state_dbg(state_dbg)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
      end
   endtask

   task automatic clear_tables();
      for (int k = 0; k < 4; k++) px_n[k] = 0;
   endtask

   task automatic add_px(input int k, input int x, input int y, input int c);
      px_x[k][px_n[k]] = 9'(x);
      px_y[k][px_n[k]] = 8'(y);
      px_c[k][px_n[k]] = 7'(c);
      px_n[k]++;
   endtask

   task automatic expect_wr(input int addr, input int data);
      exp_q.push_back({17'(addr), 6'(data)});
   endtask

   // Unselected engines present opaque on-screen pixels and done, which must be ignored.
   task automatic noise(input int k);
      for (int j = 0; j < 4; j++) begin
         if (j != k) begin
            eng_x[j*9 +: 9]     = 9'd1;
            eng_y[j*8 +: 8]     = 8'd1;
            eng_color[j*7 +: 7] = 7'h7F;
            eng_done[j]         = 1'b1;
         end
      end
   endtask

   // Engine model: pixels from the first DRAW cycle, one per cycle, then a done pulse.
   initial begin : engine_model
      int k;
      eng_done = '0; eng_x = '0; eng_y = '0; eng_color = '0;
      forever begin
         @(negedge clk);
         eng_done = '0;
         if (eng_start != 4'd0 && !reset) begin
            k = 0;
            for (int j = 0; j < 4; j++) if (eng_start[j]) k = j;
            @(negedge clk);
            @(negedge clk);
            for (int i = 0; i < px_n[k]; i++) begin
               noise(k);
               eng_x[k*9 +: 9]     = px_x[k][i];
               eng_y[k*8 +: 8]     = px_y[k][i];
               eng_color[k*7 +: 7] = px_c[k][i];
               eng_done[k]         = 1'b0;
               @(negedge clk);
            end
            noise(k);
            eng_color[k*7 +: 7] = 7'd0;
            eng_done[k]         = 1'b1;
         end
      end
   end

   initial begin : monitor
      logic [22:0] e;
      forever begin
         @(negedge clk);
         if (fb_we === 1'b1) begin
            n_checks++;
            if (exp_q.size() == 0) begin
               n_fail++;
               $display("FAIL unexpected_write: got addr %0d data 0x%0h, expected no write", fb_addr, fb_data);
            end else begin
               e = exp_q.pop_front();
               if ({fb_addr, fb_data} !== e) begin
                  n_fail++;
                  $display("FAIL fb_write: got addr %0d data 0x%0h, expected addr %0d data 0x%0h",
                           fb_addr, fb_data, e[22:6], e[5:0]);
               end
            end
         end
      end
   end

   // exp_lat counts cycles from the first eng_start to frame_done; negative skips that check.
   task automatic run_frame(input string name, input int exp_lat, input logic exp_buf);
      int cyc;
      @(negedge clk); frame_start = 1'b1;
      @(negedge clk); frame_start = 1'b0;
      if (exp_lat >= 0) check({name, "_eng_start"}, {28'd0, eng_start}, 32'd1);
      cyc = 0;
      while (frame_done !== 1'b1 && cyc < 90000) begin
         @(negedge clk);
         cyc++;
      end
      check({name, "_frame_done"}, {31'd0, frame_done}, 32'd1);
      if (exp_lat >= 0) check({name, "_latency"}, cyc, exp_lat);
      check({name, "_buf_sel"}, {31'd0, buf_sel}, {31'd0, exp_buf});
      repeat (3) @(negedge clk);
      check({name, "_idle"}, {31'd0, busy}, 32'd0);
      check({name, "_writes_left"}, exp_q.size(), 32'd0);
   endtask

   initial begin : stimulus
      int cyc, n_done;
      reset = 1'b1;
      frame_start = 1'b0;
      clear_tables();
      repeat (3) @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      check("rst_fb_we", {31'd0, fb_we}, 32'd0);
      check("rst_fb_addr", {15'd0, fb_addr}, 32'd0);
      check("rst_fb_data", {26'd0, fb_data}, 32'd0);
      check("rst_eng_start", {28'd0, eng_start}, 32'd0);
      check("rst_buf_sel", {31'd0, buf_sel}, 32'd0);
      check("rst_busy", {31'd0, busy}, 32'd0);
      check("rst_frame_done", {31'd0, frame_done}, 32'd0);
      check("rst_overrun", {31'd0, overrun}, 32'd0);
      check("rst_state", {29'd0, state_dbg}, 32'd0);

`ifdef COMPOSER_CLEAR_EN
      for (int a = 0; a < 76800; a++) expect_wr(a, 0);
      add_px(0, 7, 0, 'h42);
      expect_wr(7, 'h02);
      run_frame("clear", -1, 1'b1);

      clear_tables();
      for (int a = 0; a <= 1000; a++) expect_wr(a, 0);
      @(negedge clk); frame_start = 1'b1;
      @(negedge clk); frame_start = 1'b0;
      cyc = 0;
      while (!(fb_we === 1'b1 && fb_addr == 17'd1000) && cyc < 2000) begin
         @(negedge clk);
         cyc++;
      end
      check("clear_reached_1000", {15'd0, fb_addr}, 32'd1000);
      reset = 1'b1;
      @(negedge clk);
      check("midrst_state", {29'd0, state_dbg}, 32'd0);
      check("midrst_fb_we", {31'd0, fb_we}, 32'd0);
      check("midrst_buf_sel", {31'd0, buf_sel}, 32'd0);
      check("midrst_busy", {31'd0, busy}, 32'd0);
      reset = 1'b0;
      check("midrst_writes_left", exp_q.size(), 32'd0);
`else
      // All four engines decline: 4 x (START, SKIP, done) then FINISH.
      run_frame("all_skip", 12, 1'b1);

      // 2x2 sprite at (10,5); the 0x00 pixel is transparent.
      clear_tables();
      add_px(0, 10, 5, 'h41);
      add_px(0, 11, 5, 'h00);
      add_px(0, 10, 6, 'h7F);
      add_px(0, 11, 6, 'h45);
      expect_wr(1610, 'h01);
      expect_wr(1930, 'h3F);
      expect_wr(1931, 'h05);
      run_frame("sprite", 16, 1'b0);

      // Screen edges: last visible pixel written, one past either edge clipped.
      clear_tables();
      add_px(1, 319, 0, 'h7F);
      add_px(2, 319, 239, 'h4A);
      add_px(2, 320, 0, 'h41);
      add_px(2, 0, 240, 'h41);
      add_px(2, 0, 0, 'h40);
      add_px(3, 5, 1, 'h63);
      expect_wr(319, 'h3F);
      expect_wr(76799, 'h0A);
      expect_wr(0, 'h00);
      expect_wr(325, 'h23);
      run_frame("bounds", 18, 1'b1);

      // Second request during DRAW is dropped with an overrun pulse.
      clear_tables();
      for (int i = 0; i < 4; i++) begin
         add_px(0, i, 0, 'h55 + i);
         expect_wr(i, 'h15 + i);
      end
      @(negedge clk); frame_start = 1'b1;
      @(negedge clk); frame_start = 1'b0;
      @(negedge clk);
      @(negedge clk);
      check("ovr_in_draw", {29'd0, state_dbg}, 32'd3);
      frame_start = 1'b1;
      #1;
      check("ovr_pulse", {31'd0, overrun}, 32'd1);
      @(negedge clk);
      frame_start = 1'b0;
      #1;
      check("ovr_clear", {31'd0, overrun}, 32'd0);
      n_done = 0;
      for (int i = 0; i < 60; i++) begin
         @(negedge clk);
         if (frame_done === 1'b1) n_done++;
      end
      check("ovr_frame_done_count", n_done, 32'd1);
      check("ovr_buf_sel", {31'd0, buf_sel}, 32'd0);
      check("ovr_idle", {31'd0, busy}, 32'd0);
      check("ovr_writes_left", exp_q.size(), 32'd0);
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
